// File: rtl/mpy_pkg.sv
// Shared types and helpers for the shared shift-add multiplier arbiter.
// Round-robin pick and the FSM state encoding live here.
package mpy_pkg;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mpy_state_t;

    // Scan downward so the smallest offset from ptr wins.
    function automatic logic [IDW-1:0] rr_pick(
        input logic [NREQ-1:0] valid,
        input logic [IDW-1:0]  ptr
    );
        logic [IDW-1:0] g;
        int             idx;
        g = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (valid[idx]) begin
                g = IDW'(idx);
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mpy_shift_add_core.sv
// Sequential shift-add unsigned multiplier datapath.
// One add/shift step per cycle while step is high; load primes the operands.
module mpy_shift_add_core #(
    parameter int WIDTH = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     sum;

    // Carry lands in the top bit of the shifted product.
    always_comb begin
        sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
        if (prod_q[0]) begin
            sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            mcand_q <= a;
            prod_q  <= {{WIDTH{1'b0}}, b};
            cnt_q   <= '0;
        end else if (step) begin
            prod_q  <= {sum, prod_q[WIDTH-1:1]};
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign product = prod_q;
    assign last    = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mpy_share_arbiter.sv
// Round-robin front end sharing one shift-add multiplier among NREQ clients.
// Holds the FSM, rr pointer, owner id and the handshakes.
module mpy_share_arbiter
    import mpy_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_product,
    input  logic                  rsp_ready,
    output logic                  busy
);

    mpy_state_t         state_q;
    mpy_state_t         state_d;
    logic [IDW-1:0]     rr_q;
    logic [IDW-1:0]     id_q;
    logic [IDW-1:0]     grant;
    logic               load;
    logic               step;
    logic               last;
    logic [2*WIDTH-1:0] product;

    assign grant = rr_pick(req_valid, rr_q);

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[grant] = 1'b1;
                    load             = 1'b1;
                    state_d          = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                id_q <= grant;
            end
            if (state_q == DONE && rsp_ready) begin
                rr_q <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
            end
        end
    end

    mpy_shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .CLK     (CLK),
        .RST     (RST),
        .load    (load),
        .step    (step),
        .a       (req_a[grant*WIDTH +: WIDTH]),
        .b       (req_b[grant*WIDTH +: WIDTH]),
        .product (product),
        .last    (last)
    );

    assign rsp_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign rsp_id      = id_q;
    assign rsp_product = rsp_valid ? product : '0;

endmodule

// File: tb/tb_mpy_share_arbiter.sv
// Directed scoreboard bench for mpy_share_arbiter.
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_mpy_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    typedef struct {
        int          id;
        logic [63:0] p;
    } exp_t;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*W-1:0]  req_a = '0;
    logic [N*W-1:0]  req_b = '0;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic [2*W-1:0]  rsp_product;
    logic            rsp_ready = 1'b1;
    logic            busy;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   acc_cyc = 0;
    bit   prev_v = 1'b0;

    mpy_share_arbiter dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .rsp_ready   (rsp_ready),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: tracks accepts, checks latency, pops scoreboard on handshake.
    always @(negedge CLK) begin
        if (RST) begin
            prev_v = 1'b0;
        end else begin
            if (|(req_valid & req_ready)) begin
                acc_cnt++;
                acc_cyc = cyc;
            end
            if (rsp_valid && !prev_v) begin
                if (q.size() == 0) begin
                    chk("spurious_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    chk("latency", 64'(cyc - acc_cyc), 64'(W + 1));
                end
            end
            if (rsp_valid && rsp_ready && q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_id", 64'(rsp_id), 64'(e.id));
                chk("rsp_product", rsp_product, e.p);
            end
            prev_v = rsp_valid;
        end
    end

    task automatic wait_accept(input int start);
        int t;
        t = 0;
        while (acc_cnt == start && t < 200) begin
            @(posedge CLK);
            t++;
        end
        if (acc_cnt == start) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic issue(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [63:0] p);
        int   start;
        exp_t e;
        start = acc_cnt;
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_valid[idx] = 1'b1;
        if (push) begin
            e.id = idx;
            e.p = p;
            q.push_back(e);
        end
        wait_accept(start);
        #1 req_valid[idx] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 400) begin
            @(posedge CLK);
            t++;
        end
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
        repeat (3) @(posedge CLK);
        #1;
    endtask

    initial begin
        exp_t        e;
        int          t;
        int          acc0;
        logic [63:0] hold_p;
        logic [IW-1:0] hold_id;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_product", rsp_product, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // All four requesters valid from reset release.
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'(i + 1);
            req_b[i*W +: W] = W'(10);
        end
        for (int k = 0; k < 5; k++) begin
            e.id = k % N;
            e.p = 64'((k % N + 1) * 10);
            q.push_back(e);
        end
        @(posedge CLK);
        #1 RST = 1'b0;
        req_valid = '1;
        t = 0;
        while (acc_cnt < 5 && t < 400) begin
            @(posedge CLK);
            t++;
        end
        if (acc_cnt < 5) chk("rr_accepts", 64'(acc_cnt), 64'd5);
        #1 req_valid = '0;
        drain();

        issue(0, 32'd3, 32'd5, 1'b1, 64'd15);
        drain();
        issue(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
        drain();
        issue(3, 32'h1234_5678, 32'd0, 1'b1, 64'd0);
        drain();
        issue(1, 32'd0, 32'h9ABC_DEF0, 1'b1, 64'd0);
        drain();

        // Backpressure with a second requester waiting.
        rsp_ready = 1'b0;
        issue(0, 32'd100, 32'd200, 1'b1, 64'd20000);
        req_a[1*W +: W] = 32'd2;
        req_b[1*W +: W] = 32'd3;
        req_valid[1] = 1'b1;
        e.id = 1;
        e.p = 64'd6;
        q.push_back(e);
        t = 0;
        while (!rsp_valid && t < 100) begin
            @(negedge CLK);
            t++;
        end
        chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        hold_p = rsp_product;
        hold_id = rsp_id;
        acc0 = acc_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("bp_hold", {rsp_product[59:0], 2'(rsp_id), 1'(rsp_valid), 1'(|req_ready)},
                {hold_p[59:0], hold_id, 1'b1, 1'b0});
            chk("bp_no_accept", 64'(acc_cnt), 64'(acc0));
        end
        chk("bp_hold_product", hold_p, 64'd20000);
        @(posedge CLK);
        #1 rsp_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("bp_valid_low", 64'(rsp_valid), 64'd0);
        wait_accept(acc0);
        #1 req_valid[1] = 1'b0;
        drain();

        // Reset during RUN aborts the operation.
        issue(2, 32'd9, 32'd9, 1'b0, 64'd0);
        repeat (10) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("abort_req_ready", 64'(req_ready), 64'd0);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_rsp_id", 64'(rsp_id), 64'd0);
        chk("abort_rsp_product", rsp_product, 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (40) @(posedge CLK);
        #1;
        issue(0, 32'd7, 32'd6, 1'b1, 64'd42);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
